// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation datapath.
package rsa_pkg;

  localparam int unsigned DefWidth = 8;
  localparam logic [DefWidth-1:0] ONE = DefWidth'(1);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StMul,
    StSqr,
    StShift,
    StHold
  } state_e;

endpackage

// File: rtl/rsa_modexp_datapath_if.sv
// Controller <-> datapath handshake: operand buses, control strobes, done and result.
interface rsa_modexp_datapath_if #(
  parameter int unsigned WIDTH = rsa_pkg::DefWidth
);
  logic [WIDTH-1:0] n_in;
  logic [WIDTH-1:0] c_in;
  logic [WIDTH-1:0] b_in;
  logic             load_n;
  logic             load_c;
  logic             load_b;
  logic             preset;
  logic             s;
  logic             load_r;
  logic             done;
  logic [WIDTH-1:0] r_out;

  modport master (
    output n_in, c_in, b_in, load_n, load_c, load_b, preset, s, load_r,
    input  done, r_out
  );

  modport slave (
    input  n_in, c_in, b_in, load_n, load_c, load_b, preset, s, load_r,
    output done, r_out
  );
endinterface

// File: rtl/rsa_modmul.sv
// Interleaved MSB-first modular multiplier: p = a*x mod n, one bit of a per enabled cycle.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] n_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] p_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             busy_q, busy_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH:0]   nx, dbl, dbl_r, sum;
  logic [WIDTH-1:0] step_p;

  always_comb begin
    nx     = {1'b0, n_i};
    dbl    = {p_q, 1'b0};
    dbl_r  = (dbl >= nx) ? dbl - nx : dbl;
    sum    = a_i[cnt_q] ? dbl_r + {1'b0, x_i} : dbl_r;
    step_p = WIDTH'((sum >= nx) ? sum - nx : sum);
  end

  // p_o is the value this cycle's step produces; it is the product when done_o is high.
  assign p_o    = step_p;
  assign busy_o = busy_q;
  assign done_o = busy_q & en_i & (cnt_q == '0);

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    p_d    = p_q;
    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
      p_d    = '0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CntW'(WIDTH - 1);
      p_d    = '0;
    end else if (busy_q && en_i) begin
      p_d = step_p;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      p_q    <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      p_q    <= p_d;
    end
  end

endmodule

// File: rtl/rsa_modexp_datapath.sv
// Right-to-left square-and-multiply datapath computing r = c^b mod n.
// Optional cycle counter output enabled by defining RSA_CYCLE_CNT_EN.
module rsa_modexp_datapath
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
`ifdef RSA_CYCLE_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rsa_modexp_datapath_if.slave bus
`ifdef RSA_CYCLE_CNT_EN
  ,
  output logic [CNT_W-1:0]     cycles
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d, c_q, c_d, b_q, b_d;
  logic [WIDTH-1:0] base_q, base_d, e_q, e_d, acc_q, acc_d, r_q, r_d;
  logic             done_q, done_d;
  logic             any_load, preset_act;
  logic             mm_start, mm_abort, mm_busy, mm_done;
  logic [WIDTH-1:0] mm_a, mm_p;

  assign any_load   = bus.load_n | bus.load_c | bus.load_b;
  assign preset_act = bus.preset & ~any_load;
  assign mm_abort   = any_load | bus.preset;
  assign mm_a       = (state_q == StSqr) ? base_q : acc_q;

  rsa_modmul #(
    .WIDTH (WIDTH)
  ) u_modmul (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (bus.s),
    .start_i (mm_start),
    .abort_i (mm_abort),
    .a_i     (mm_a),
    .x_i     (base_q),
    .n_i     (n_q),
    .busy_o  (mm_busy),
    .done_o  (mm_done),
    .p_o     (mm_p)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    c_d      = c_q;
    b_d      = b_q;
    base_d   = base_q;
    e_d      = e_q;
    acc_d    = acc_q;
    done_d   = done_q;
    mm_start = 1'b0;
    r_d      = bus.load_r ? acc_q : r_q;

    if (any_load) begin
      if (bus.load_n) n_d = bus.n_in;
      if (bus.load_c) c_d = bus.c_in;
      if (bus.load_b) b_d = bus.b_in;
      done_d  = 1'b0;
      state_d = StIdle;
    end else if (preset_act) begin
      acc_d   = WIDTH'(ONE);
      base_d  = c_q;
      e_d     = b_q;
      done_d  = 1'b0;
      state_d = StCheck;
    end else if (bus.s) begin
      case (state_q)
        StCheck: begin
          if (e_q == '0) begin
            done_d  = 1'b1;
            state_d = StHold;
          end else if (e_q[0]) begin
            mm_start = 1'b1;
            state_d  = StMul;
          end else if ((e_q >> 1) == '0) begin
            state_d = StShift;
          end else begin
            mm_start = 1'b1;
            state_d  = StSqr;
          end
        end
        StMul: begin
          if (mm_busy && mm_done) begin
            acc_d = mm_p;
            // The last exponent bit never needs its square.
            if ((e_q >> 1) == '0) begin
              state_d = StShift;
            end else begin
              mm_start = 1'b1;
              state_d  = StSqr;
            end
          end
        end
        StSqr: begin
          if (mm_busy && mm_done) begin
            base_d  = mm_p;
            state_d = StShift;
          end
        end
        StShift: begin
          e_d     = e_q >> 1;
          state_d = StCheck;
        end
        StIdle, StHold: state_d = state_q;
        default:        state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      n_q     <= '0;
      c_q     <= '0;
      b_q     <= '0;
      base_q  <= '0;
      e_q     <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      c_q     <= c_d;
      b_q     <= b_d;
      base_q  <= base_d;
      e_q     <= e_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      r_q     <= r_d;
    end
  end

  assign bus.done  = done_q;
  assign bus.r_out = r_q;

`ifdef RSA_CYCLE_CNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (preset_act) begin
      cyc_d = '0;
    end else if (!any_load && bus.s && state_q != StIdle && state_q != StHold &&
                 cyc_q != '1) begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_rsa_modexp_datapath.sv
// Scoreboard bench for rsa_modexp_datapath: directed modexp runs with hand-computed results.
module tb_rsa_modexp_datapath;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] exp_q[$];

  rsa_modexp_datapath_if bus ();

`ifdef RSA_CYCLE_CNT_EN
  logic [15:0] cycles;
`endif

  rsa_modexp_datapath dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef RSA_CYCLE_CNT_EN
    ,
    .cycles (cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every load_r edge presents a result; pop and compare.
  initial begin
    forever begin
      @(posedge clk);
      if (bus.load_r === 1'b1) begin
        #2;
        if (exp_q.size() == 0) begin
          chk("unexpected r_out", int'(bus.r_out), -1);
        end else begin
          chk("r_out", int'(bus.r_out), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(input logic [7:0] n, input logic [7:0] c, input logic [7:0] b);
    bus.n_in   = n;
    bus.c_in   = c;
    bus.b_in   = b;
    bus.load_n = 1'b1;
    bus.load_c = 1'b1;
    bus.load_b = 1'b1;
    step();
    bus.load_n = 1'b0;
    bus.load_c = 1'b0;
    bus.load_b = 1'b0;
  endtask

  // Preset with s high; the preset edge counts as cycle 1. Returns the cycle on which
  // done is first seen, or the bound if it never rises.
  task automatic run(input int pause_at, input int pause_len, output int cyc);
    bus.preset = 1'b1;
    bus.s      = 1'b1;
    step();
    bus.preset = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 300) begin
      if (cyc == pause_at) begin
        bus.s = 1'b0;
        repeat (pause_len) begin
          step();
          cyc++;
        end
        bus.s = 1'b1;
      end
      step();
      cyc++;
    end
  endtask

  task automatic read_r(input logic [7:0] req);
    exp_q.push_back(req);
    bus.load_r = 1'b1;
    step();
    bus.load_r = 1'b0;
    step();
  endtask

  int cyc;

  initial begin
    rst_n      = 1'b0;
    bus.n_in   = '0;
    bus.c_in   = '0;
    bus.b_in   = '0;
    bus.load_n = 1'b0;
    bus.load_c = 1'b0;
    bus.load_b = 1'b0;
    bus.preset = 1'b0;
    bus.s      = 1'b0;
    bus.load_r = 1'b0;
    #12;
    chk("reset done", int'(bus.done), 0);
    chk("reset r_out", int'(bus.r_out), 0);
    #1 rst_n = 1'b1;
    step();

    // 4^3 mod 33 = 31
    load_all(8'd33, 8'd4, 8'd3);
    run(0, 0, cyc);
    chk("latency b=3", cyc, 30);
`ifdef RSA_CYCLE_CNT_EN
    chk("cycles b=3", int'(cycles), 29);
`endif
    read_r(8'd31);

    // Round trip: 2^7 mod 33 = 29, 29^3 mod 33 = 2
    load_all(8'd33, 8'd2, 8'd7);
    chk("done cleared by load", int'(bus.done), 0);
    run(0, 0, cyc);
    chk("latency b=7", cyc, 48);
    read_r(8'd29);
    load_all(8'd33, 8'd29, 8'd3);
    run(0, 0, cyc);
    chk("latency decrypt", cyc, 30);
    read_r(8'd2);

    // b = 0 -> 1 after a single step cycle; c = 0 -> 0
    load_all(8'd33, 8'd5, 8'd0);
    run(0, 0, cyc);
    chk("latency b=0", cyc, 2);
    read_r(8'd1);
    load_all(8'd33, 8'd0, 8'd5);
    run(0, 0, cyc);
    chk("latency b=5", cyc, 40);
    read_r(8'd0);

    // 10-cycle pause in the middle of the first multiply
    load_all(8'd33, 8'd4, 8'd3);
    run(5, 10, cyc);
    chk("latency paused", cyc, 40);
`ifdef RSA_CYCLE_CNT_EN
    chk("cycles paused", int'(cycles), 29);
`endif
    read_r(8'd31);

    // Abort by load_b mid-run; without a new preset done must stay low
    load_all(8'd33, 8'd4, 8'd3);
    bus.preset = 1'b1;
    bus.s      = 1'b1;
    step();
    bus.preset = 1'b0;
    repeat (12) step();
    bus.b_in   = 8'd3;
    bus.load_b = 1'b1;
    step();
    bus.load_b = 1'b0;
    chk("done after abort", int'(bus.done), 0);
    repeat (40) step();
    chk("done idle after abort", int'(bus.done), 0);
    run(0, 0, cyc);
    chk("latency after abort", cyc, 30);
    read_r(8'd31);

    // Asynchronous reset in the middle of the first square
    load_all(8'd33, 8'd4, 8'd3);
    bus.preset = 1'b1;
    bus.s      = 1'b1;
    step();
    bus.preset = 1'b0;
    repeat (13) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async reset done", int'(bus.done), 0);
    chk("async reset r_out", int'(bus.r_out), 0);
    #10 rst_n = 1'b1;
    step();
    load_all(8'd33, 8'd4, 8'd3);
    run(0, 0, cyc);
    chk("latency after reset", cyc, 30);
    read_r(8'd31);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_datapath.md
Name: rsa_modexp_datapath

Overview:
- Responder side of the RSA controller/datapath handshake; computes r = c^b mod n by right-to-left square-and-multiply.
- Consumes the controller's strobes (load_n, load_c, load_b, preset, s, load_r) and returns done.
- Sits beside the controller inside the RSA top; one instance serves both encryption (b = e) and decryption (b = d).

Parameters:
- WIDTH, 8, bit width of n, c, b and r.
- CNT_W, 16, width of the optional cycle counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- n_in  in  WIDTH  modulus; precondition n >= 2
- c_in  in  WIDTH  base (message or ciphertext); precondition c < n
- b_in  in  WIDTH  exponent
- load_n  in  1  capture n_in
- load_c  in  1  capture c_in
- load_b  in  1  capture b_in
- preset  in  1  initialise the computation
- s  in  1  step enable; datapath advances only while high
- load_r  in  1  copy the accumulator to r_out
- done  out  1  result ready (registered)
- r_out  out  WIDTH  result register

Behaviour:
- Async reset:
  - done = 0, r_out = 0.
  - Internal registers n, base, e, acc, P and bit index cleared; FSM = IDLE.
- Any load_n, load_c or load_b:
  - Captures the corresponding input on that edge.
  - Clears done and forces IDLE; this aborts any computation in progress.
- preset (priority below loads): acc = 1, base = c, e = b, done = 0, FSM = CHECK.
- s low: all state held, including mid-multiply (pause). preset and loads still act.
- FSM advances only while s = 1:
  - CHECK, 1 cycle:
    - e == 0 -> set done, go to HOLD.
    - else if e[0] -> MUL.
    - else -> SQR, or SHIFT when e>>1 == 0.
  - MUL, WIDTH cycles: acc = acc*base mod n. Then SQR, or SHIFT when e>>1 == 0.
  - SQR, WIDTH cycles: base = base*base mod n. Then SHIFT.
  - SHIFT, 1 cycle: e = e >> 1, then CHECK.
  - HOLD: done stays 1 until the next load or preset, or until reset.
- Modular multiply, interleaved MSB-first, one multiplier bit per cycle:
  - P = 0 at start.
  - Each cycle: P = 2P; if P >= n then P -= n.
  - Then if a[i]: P = P + x; if P >= n then P -= n.
  - Intermediates are WIDTH+1 bits. Operands < n guarantee P < n after every cycle.
- load_r: r_out <= acc on that edge, independent of s. Otherwise r_out holds.
- done can never be 1 before a preset has occurred since the last load, so the controller's read-state done check falls through to calc.
- Latency after preset, s held high: each exponent bit costs CHECK + SHIFT + WIDTH·[bit=1] + WIDTH·[not last bit], plus one final CHECK.
- Boundaries:
  - b = 0 -> done after 1 step cycle, r = 1.
  - c = 0, b > 0 -> r = 0.
  - b = all-ones -> no overflow, because e is shifted logically.
  - Preconditions violated (n < 2 or c >= n) -> result undefined, but the FSM still terminates.

Optional Feature:
- Macro RSA_CYCLE_CNT_EN.
- Defined:
  - Adds output cycles [CNT_W-1:0].
  - Cleared by preset.
  - Increments on every s-high cycle while the FSM is not in IDLE or HOLD.
  - Saturates at all-ones and freezes when done rises.
  - Reset value 0.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Package rsa_pkg: FSM state encoding (IDLE, CHECK, MUL, SQR, SHIFT, HOLD), default WIDTH, and constant ONE = 1 zero-extended to WIDTH.
- Sub-module rsa_modmul:
  - Interface: start/busy/done plus a, x, n, p.
  - Implements the interleaved multiplier with its own bit counter and an enable input tied to s.
  - The top instantiates it once and muxes operands (acc/base or base/base).

Test Plan:
- Load n=33, c=4, b=3; preset; s high -> done rises on the 30th s-cycle after preset; load_r -> r_out = 31.
- Round trip, n=33: encrypt with c=2, b=7 -> r_out = 29; reload with c=29, b=3 -> r_out = 2.
- b=0, c=5, n=33 -> done after 1 s-cycle; r_out = 1. Separately, c=0, b=5 -> r_out = 0.
- Drop s for 10 cycles mid-MUL during the n=33, c=4, b=3 run -> same result, done delayed exactly 10 cycles. With RSA_CYCLE_CNT_EN, cycles = 29.
- Pulse load_b mid-computation -> done stays 0 and FSM returns to IDLE; then preset with b=3 -> r_out = 31.
- Deassert rst_n asynchronously mid-SQR -> done = 0 and r_out = 0 immediately; after release, a full n=33, c=4, b=3 run gives 31.
